// File: rtl/dcache_port_arbiter.sv
// Two-master arbiter for the single DCache request port, with in-order response routing.
// Optional M1 anti-starvation counter is built only when DCACHE_ARB_STARVE_EN is defined.
module dcache_port_arbiter #(
  parameter int unsigned MAX_OUT      = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        dc_req,
  output logic        dc_wr,
  output logic [1:0]  dc_size,
  output logic [3:0]  dc_wstrb,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  input  logic        dc_addr_ok,
  input  logic        dc_data_ok,
  input  logic [31:0] dc_rdata,
  output logic        busy,
  output logic        proto_err
);

  localparam int unsigned PtrW = $clog2(MAX_OUT);
  localparam int unsigned CntW = $clog2(MAX_OUT) + 1;

  typedef enum logic [1:0] {StIdle, StHold0, StHold1} state_e;

  state_e state_q, state_d;

  logic            gnt_vld, gnt_id, win_req, starve_win;
  logic            push, pop, fifo_full, fifo_empty;
  logic            head_id, head_kill, proto_err_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [MAX_OUT-1:0] fid_q, fkill_q, fvld_q;

`ifdef DCACHE_ARB_STARVE_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic [StarveW-1:0] starve_q, starve_d;

  assign starve_win = m1_req && (starve_q == StarveW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!m1_req || m1_addr_ok) begin
      starve_d = '0;
    end else if (!(gnt_vld && gnt_id) && (starve_q != StarveW'(STARVE_LIMIT))) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign starve_win = 1'b0;
`endif

  // Grant is suppressed while reset is held so every output reads zero during reset.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (starve_win) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end else if (m0_req) begin
          gnt_vld = 1'b1;
        end else if (m1_req) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
      end
      StHold0: gnt_vld = 1'b1;
      StHold1: begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
      default: ;
    endcase
    if (!reset) gnt_vld = 1'b0;
  end

  assign win_req = gnt_id ? m1_req : m0_req;
  assign dc_req  = gnt_vld && win_req && !fifo_full && !((state_q == StHold0) && flush);

  always_comb begin
    dc_wr    = 1'b0;
    dc_size  = '0;
    dc_wstrb = '0;
    dc_addr  = '0;
    dc_wdata = '0;
    if (gnt_vld) begin
      dc_wr    = gnt_id ? m1_wr    : m0_wr;
      dc_size  = gnt_id ? m1_size  : m0_size;
      dc_wstrb = gnt_id ? m1_wstrb : m0_wstrb;
      dc_addr  = gnt_id ? m1_addr  : m0_addr;
      dc_wdata = gnt_id ? m1_wdata : m0_wdata;
    end
  end

  assign push       = dc_req && dc_addr_ok;
  assign m0_addr_ok = push && !gnt_id;
  assign m1_addr_ok = push && gnt_id;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (dc_req && !dc_addr_ok) state_d = gnt_id ? StHold1 : StHold0;
      StHold0: if (flush || dc_addr_ok) state_d = StIdle;
      StHold1: if (dc_addr_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  assign fifo_full  = (cnt_q == CntW'(MAX_OUT));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = dc_data_ok && !fifo_empty;
  assign head_id    = fid_q[rd_ptr_q];
  assign head_kill  = fkill_q[rd_ptr_q];

  assign m0_data_ok = pop && !head_id && !head_kill && !flush;
  assign m1_data_ok = pop && head_id;
  assign m0_rdata   = dc_rdata;
  assign m1_rdata   = dc_rdata;

  // Push and pop never share a slot: push needs not-full, pop needs not-empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      fid_q    <= '0;
      fkill_q  <= '0;
      fvld_q   <= '0;
    end else begin
      for (int i = 0; i < int'(MAX_OUT); i++) begin
        if (flush && fvld_q[i] && !fid_q[i]) fkill_q[i] <= 1'b1;
      end
      if (pop) begin
        fvld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        fid_q[wr_ptr_q]   <= gnt_id;
        fkill_q[wr_ptr_q] <= flush && !gnt_id;
        fvld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) proto_err_q <= 1'b0;
    else        proto_err_q <= proto_err_q || (dc_data_ok && fifo_empty);
  end

  assign proto_err = proto_err_q;
  assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: arbitration, hold, FIFO limits, flush, starvation,
// protocol error and asynchronous reset. Inputs change on the falling edge.
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dc_req, dc_wr, dc_addr_ok, dc_data_ok;
  logic [1:0]  dc_size;
  logic [3:0]  dc_wstrb;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic        busy, proto_err;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.MAX_OUT(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
    .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
    .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_size(dc_size), .dc_wstrb(dc_wstrb),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_addr_ok(dc_addr_ok),
    .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata),
    .busy(busy), .proto_err(proto_err)
  );

  task automatic idle_inputs();
    flush = 0; m0_req = 0; m0_wr = 0; m0_size = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_size = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
    dc_addr_ok = 0; dc_data_ok = 0; dc_rdata = 0;
  endtask

  // Advance to the next falling edge; callers drive, wait #1, then compare.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 0; idle_inputs();
    cyc(); #1;
    chk_cnt++; if ({dc_req, busy, proto_err, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}
                   !== 7'b0) $display("FAIL reset_ctrl got %b want 0",
        {dc_req, busy, proto_err, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok});
    else pass_cnt++;
    chk_cnt++; if (dc_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", dc_addr);
    else pass_cnt++;
    cyc(); reset = 1;
  endtask

  task automatic test_simultaneous();
    cyc(); m0_req = 1; m0_addr = 32'h1000; m1_req = 1; m1_wr = 1; m1_addr = 32'h2000;
    m1_wdata = 32'hCAFE_0001; m1_wstrb = 4'hF; dc_addr_ok = 1; #1;
    chk_cnt++; if ({dc_req, m0_addr_ok, m1_addr_ok} !== 3'b110)
      $display("FAIL sim_c0_ok got %b want 110", {dc_req, m0_addr_ok, m1_addr_ok});
    else pass_cnt++;
    chk_cnt++; if (dc_addr !== 32'h1000) $display("FAIL sim_c0_addr got %h want 1000", dc_addr);
    else pass_cnt++;
    cyc(); m0_req = 0; #1;
    chk_cnt++; if ({m0_addr_ok, m1_addr_ok, dc_wr} !== 3'b011)
      $display("FAIL sim_c1_ok got %b want 011", {m0_addr_ok, m1_addr_ok, dc_wr});
    else pass_cnt++;
    chk_cnt++; if (dc_wdata !== 32'hCAFE_0001)
      $display("FAIL sim_c1_wdata got %h want cafe0001", dc_wdata);
    else pass_cnt++;
    cyc(); m1_req = 0; m1_wr = 0; dc_addr_ok = 0; dc_data_ok = 1; dc_rdata = 32'hAAAA_0000; #1;
    chk_cnt++; if ({m0_data_ok, m1_data_ok, dc_req} !== 3'b100 || m0_rdata !== 32'hAAAA_0000)
      $display("FAIL sim_rsp0 got %b/%h want 100/aaaa0000", {m0_data_ok, m1_data_ok, dc_req},
               m0_rdata);
    else pass_cnt++;
    cyc(); dc_rdata = 32'hBBBB_0001; #1;
    chk_cnt++; if ({m0_data_ok, m1_data_ok} !== 2'b01 || m1_rdata !== 32'hBBBB_0001)
      $display("FAIL sim_rsp1 got %b/%h want 01/bbbb0001", {m0_data_ok, m1_data_ok}, m1_rdata);
    else pass_cnt++;
    cyc(); idle_inputs(); #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL sim_idle busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    cyc(); m1_req = 1; m1_addr = 32'h3300; #1;
    chk_cnt++; if (dc_req !== 1'b1 || dc_addr !== 32'h3300)
      $display("FAIL hold_c0 got %b/%h want 1/3300", dc_req, dc_addr);
    else pass_cnt++;
    for (int i = 1; i < 3; i++) begin
      cyc(); m0_req = 1; m0_addr = 32'h4400; #1;
      chk_cnt++; if (dc_addr !== 32'h3300 || m0_addr_ok !== 1'b0 || busy !== 1'b1)
        $display("FAIL hold_c%0d got %h/%b/%b want 3300/0/1", i, dc_addr, m0_addr_ok, busy);
      else pass_cnt++;
    end
    cyc(); dc_addr_ok = 1; #1;
    chk_cnt++; if ({m1_addr_ok, m0_addr_ok} !== 2'b10 || dc_addr !== 32'h3300)
      $display("FAIL hold_rel got %b/%h want 10/3300", {m1_addr_ok, m0_addr_ok}, dc_addr);
    else pass_cnt++;
    cyc(); m1_req = 0; #1;
    chk_cnt++; if ({m1_addr_ok, m0_addr_ok} !== 2'b01 || dc_addr !== 32'h4400)
      $display("FAIL hold_m0 got %b/%h want 01/4400", {m1_addr_ok, m0_addr_ok}, dc_addr);
    else pass_cnt++;
    cyc(); m0_req = 0; dc_addr_ok = 0; dc_data_ok = 1; #1;
    chk_cnt++; if ({m0_data_ok, m1_data_ok} !== 2'b01)
      $display("FAIL hold_rsp0 got %b want 01", {m0_data_ok, m1_data_ok});
    else pass_cnt++;
    cyc(); #1;
    chk_cnt++; if ({m0_data_ok, m1_data_ok} !== 2'b10)
      $display("FAIL hold_rsp1 got %b want 10", {m0_data_ok, m1_data_ok});
    else pass_cnt++;
    cyc(); idle_inputs();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) begin
      cyc(); m0_req = 1; m0_addr = 32'h100 + 32'(i * 4); dc_addr_ok = 1; #1;
      chk_cnt++; if (m0_addr_ok !== 1'b1) $display("FAIL full_push%0d got %b want 1", i,
                                                   m0_addr_ok);
      else pass_cnt++;
    end
    cyc(); m0_addr = 32'h110; #1;
    chk_cnt++; if (dc_req !== 1'b0 || m0_addr_ok !== 1'b0)
      $display("FAIL full_block got %b/%b want 0/0", dc_req, m0_addr_ok);
    else pass_cnt++;
    cyc(); dc_data_ok = 1; #1;
    chk_cnt++; if (dc_req !== 1'b0 || m0_data_ok !== 1'b1)
      $display("FAIL full_pop_same got %b/%b want 0/1", dc_req, m0_data_ok);
    else pass_cnt++;
    cyc(); dc_data_ok = 0; #1;
    chk_cnt++; if (m0_addr_ok !== 1'b1 || dc_addr !== 32'h110)
      $display("FAIL full_resume got %b/%h want 1/110", m0_addr_ok, dc_addr);
    else pass_cnt++;
    cyc(); m0_req = 0; dc_addr_ok = 0; dc_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_cnt++; if (m0_data_ok !== 1'b1) $display("FAIL full_drain%0d got %b want 1", i,
                                                   m0_data_ok);
      else pass_cnt++;
      cyc();
    end
    dc_data_ok = 0; #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL full_empty busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    cyc(); m0_req = 1; dc_addr_ok = 1; m0_addr = 32'h500;
    cyc(); m0_addr = 32'h504;
    cyc(); m0_req = 0; m1_req = 1; m1_addr = 32'h600; #1;
    chk_cnt++; if (m1_addr_ok !== 1'b1) $display("FAIL flush_m1push got %b want 1", m1_addr_ok);
    else pass_cnt++;
    cyc(); m1_req = 0; dc_addr_ok = 0; flush = 1;
    cyc(); flush = 0; dc_data_ok = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_cnt++; if ({m0_data_ok, m1_data_ok, busy} !== 3'b001)
        $display("FAIL flush_kill%0d got %b want 001", i, {m0_data_ok, m1_data_ok, busy});
      else pass_cnt++;
      cyc();
    end
    #1;
    chk_cnt++; if ({m0_data_ok, m1_data_ok} !== 2'b01)
      $display("FAIL flush_m1rsp got %b want 01", {m0_data_ok, m1_data_ok});
    else pass_cnt++;
    cyc(); dc_data_ok = 0; #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy);
    else pass_cnt++;
    // Flush while M0 is held un-accepted abandons the request.
    cyc(); m0_req = 1; m0_addr = 32'h700;
    cyc(); flush = 1; #1;
    chk_cnt++; if (dc_req !== 1'b0) $display("FAIL hold0_flush dc_req got %b want 0", dc_req);
    else pass_cnt++;
    cyc(); flush = 0; m0_req = 0; #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL hold0_flush busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_starve();
    int unsigned n0 = 0;
    int unsigned n1 = 0;
`ifdef DCACHE_ARB_STARVE_EN
    for (int i = 1; i <= 9; i++) begin
      cyc(); m0_req = 1; m1_req = 1; dc_addr_ok = 1; dc_data_ok = (i > 1); #1;
      chk_cnt++; if ({m0_addr_ok, m1_addr_ok} !== ((i == 9) ? 2'b01 : 2'b10))
        $display("FAIL starve_c%0d got %b want %b", i, {m0_addr_ok, m1_addr_ok},
                 (i == 9) ? 2'b01 : 2'b10);
      else pass_cnt++;
    end
    cyc(); idle_inputs(); dc_data_ok = 1; #1;
    chk_cnt++; if ({m0_data_ok, m1_data_ok} !== 2'b01)
      $display("FAIL starve_rsp got %b want 01", {m0_data_ok, m1_data_ok});
    else pass_cnt++;
`else
    for (int i = 1; i <= 100; i++) begin
      cyc(); m0_req = 1; m1_req = 1; dc_addr_ok = 1; dc_data_ok = (i > 1); #1;
      if (m0_addr_ok === 1'b1) n0++;
      if (m1_addr_ok === 1'b1) n1++;
    end
    chk_cnt++; if (n1 != 0 || n0 != 100)
      $display("FAIL strict_prio got m0=%0d m1=%0d want m0=100 m1=0", n0, n1);
    else pass_cnt++;
    cyc(); idle_inputs(); dc_data_ok = 1; #1;
    chk_cnt++; if ({m0_data_ok, m1_data_ok} !== 2'b10)
      $display("FAIL strict_rsp got %b want 10", {m0_data_ok, m1_data_ok});
    else pass_cnt++;
`endif
    cyc(); idle_inputs(); #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL starve_busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_proto_err();
    cyc(); dc_data_ok = 1; #1;
    chk_cnt++; if ({m0_data_ok, m1_data_ok, proto_err} !== 3'b000)
      $display("FAIL proto_c0 got %b want 000", {m0_data_ok, m1_data_ok, proto_err});
    else pass_cnt++;
    cyc(); dc_data_ok = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++; if (proto_err !== 1'b1) $display("FAIL proto_sticky%0d got %b want 1", i,
                                                  proto_err);
      else pass_cnt++;
      cyc();
    end
  endtask

  task automatic test_async_reset();
    m0_req = 1; m0_addr = 32'h800; #1;
    cyc(); #1;
    chk_cnt++; if (busy !== 1'b1 || dc_req !== 1'b1)
      $display("FAIL areset_hold got %b/%b want 1/1", busy, dc_req);
    else pass_cnt++;
    reset = 0; #1;
    chk_cnt++; if ({dc_req, busy, proto_err, m0_addr_ok} !== 4'b0 || dc_addr !== 32'h0)
      $display("FAIL areset_out got %b/%h want 0000/0", {dc_req, busy, proto_err, m0_addr_ok},
               dc_addr);
    else pass_cnt++;
    cyc(); m0_req = 0; reset = 1;
    cyc(); dc_data_ok = 1;
    cyc(); dc_data_ok = 0; #1;
    chk_cnt++; if (proto_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL areset_late got %b/%b want 1/0", proto_err, busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_hold();
    test_fifo_full();
    test_flush();
    test_starve();
    test_proto_err();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Shares the single DCache request port between two data-side masters: the pre-memory pipeline stage (M0, loads/stores) and the cache-maintenance engine (M1, CACHE-instruction and writeback traffic). It sits between those masters and the DCache. It locks the grant across an unaccepted request and tracks outstanding transactions in order so each `data_ok` returns to the correct master. Pipeline flushes kill M0's in-flight responses without disturbing M1.

## Interface
- `MAX_OUT`, 4: outstanding-transaction FIFO depth (power of two, ≥2).
- `STARVE_LIMIT`, 8: consecutive cycles M1 may be refused before it is forced to win (only with `DCACHE_ARB_STARVE_EN`).

Clocking and reset: one clock; reset is asynchronous and active-low.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `flush` in 1: pipeline flush; kills M0 responses.
- `mN_req` in 1: request valid, N = 0 or 1.
- `mN_wr` in 1: 1 = write.
- `mN_size` in 2: access size.
- `mN_wstrb` in 4: byte strobes.
- `mN_addr` in 32: address.
- `mN_wdata` in 32: write data.
- `mN_addr_ok` out 1: request accepted this cycle.
- `mN_data_ok` out 1: response for master N this cycle.
- `mN_rdata` out 32: read data; this is `dc_rdata` passed through.
- `dc_req`, `dc_wr`, `dc_size`, `dc_wstrb`, `dc_addr`, `dc_wdata` out: the muxed request to the DCache.
- `dc_addr_ok` in 1: DCache accepted the request.
- `dc_data_ok` in 1: DCache response valid.
- `dc_rdata` in 32: DCache read data.
- `busy` out 1: state ≠ IDLE, or the FIFO is non-empty.
- `proto_err` out 1: sticky; set by `dc_data_ok` while the FIFO is empty.

## Operation
- Grant FSM states:
  - IDLE: arbitrate combinationally.
  - HOLD0 / HOLD1: the grant is locked to M0 / M1 until `dc_addr_ok`.
- IDLE arbitration:
  - M0 wins over M1, except when the starve counter has reached `STARVE_LIMIT`; then M1 wins.
  - No winner if neither master requests.
- `dc_req` = winner's `mN_req` AND NOT `fifo_full`.
- Request fields are muxed from the granted master and are all-zero when there is no grant.
- Transitions:
  - IDLE→HOLDx: `dc_req` asserted for master x and `!dc_addr_ok`.
  - HOLDx→IDLE: `dc_addr_ok`.
  - HOLD0→IDLE: `flush`; `dc_req` is forced low that cycle.
  - HOLD1 ignores `flush`.
- `mN_addr_ok` = `dc_req` & `dc_addr_ok` & grant==N.
- Outstanding FIFO entries hold {id, kill}.
  - Push {grant, flush & grant==0} on `dc_req & dc_addr_ok`.
  - Pop on `dc_data_ok` when the FIFO is non-empty.
  - Push and pop in the same cycle leave the count unchanged.
  - Count width is clog2(`MAX_OUT`)+1.
  - Pointers wrap modulo `MAX_OUT`.
- `flush` sets `kill` on every valid entry with id 0. This includes the entry being pushed that cycle.
- Response routing:
  - `m0_data_ok` = `dc_data_ok` & head.id==0 & !head.kill & !`flush`.
  - `m1_data_ok` = `dc_data_ok` & head.id==1.
  - Killed entries are popped silently.
- `dc_data_ok` with an empty FIFO: no pop, no `mN_data_ok`, `proto_err` is set and stays set until reset.

## Timing
- Request path is zero latency: `mN_req` to `dc_req` is combinational in IDLE.
- Response path is zero latency: `dc_data_ok` to `mN_data_ok` is combinational.
- `dc_req` is never asserted while the FIFO is full, even if `dc_data_ok` pops in the same cycle. Issue resumes the next cycle.
- In HOLDx the granted request stays on `dc_*` regardless of the other master. Masters must hold their request stable until `addr_ok`; only M0 may drop it, and only on `flush`.
- Back-to-back accepts are allowed every cycle while the FIFO is not full.
- Reset values:
  - State IDLE; FIFO empty; pointers and count 0.
  - Starve counter 0; `proto_err` 0.
  - All outputs 0.
- Reset mid-transaction discards all tracking immediately. Late `dc_data_ok` after reset sets `proto_err`.

## Configuration
- `DCACHE_ARB_STARVE_EN` defined:
  - A saturating counter increments on each cycle `m1_req` is high and M1 is not granted.
  - It clears on an `m1_addr_ok` or while `m1_req` is low.
  - When it equals `STARVE_LIMIT`, M1 wins the next IDLE arbitration.
- Undefined: strict M0 priority; the counter is not built and M1 can starve indefinitely.

## Test plan
- Simultaneous `m0_req`/`m1_req`, `dc_addr_ok`=1 → M0 accepted cycle 0, M1 accepted cycle 1. FIFO ids {0,1}; two `dc_data_ok` pulses → `m0_data_ok` then `m1_data_ok` with matching `dc_rdata`.
- M1 request, `dc_addr_ok` held low 3 cycles while M0 requests → FSM in HOLD1, `dc_addr`=`m1_addr` all 3 cycles; M0 accepted the cycle after M1's `addr_ok`.
- `MAX_OUT`=4, 4 accepted M0 loads, no `data_ok` → `dc_req`=0 on the 5th. One `dc_data_ok` → the 5th issues the next cycle; pointers wrap to 0 correctly.
- Two M0 and one M1 outstanding, `flush` pulsed → next three `dc_data_ok`: no `m0_data_ok` for the M0 entries, `m1_data_ok`=1 for the M1 entry, `busy` drops to 0 after the last.
- `STARVE_EN`, `STARVE_LIMIT`=8, `m0_req` always high with `addr_ok`=1, `m1_req` high → M1 granted on the 9th cycle. Without the macro, M1 is never granted in 100 cycles.
- `dc_data_ok` with empty FIFO → `proto_err`=1 and held. Async reset low mid-HOLD0 → all outputs 0 and state IDLE before the next clock edge.
